// File: rtl/perf_counter_bank_pkg.sv
// Shared types and defaults for the performance counter bank.
// Build option: PERF_SATURATE_EN selects saturating counters (default wraps).
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_INC_W    = 4;
  localparam int DEF_HALT_ADJ = 8;

  // Select must also reach the extra cycle-counter slot at index n.
  function automatic int sel_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter: widened add, wrap or saturate, sticky carry, optional clamped halt adjust.
// Build option: PERF_SATURATE_EN pins an overflowing count at all-ones.
module perf_counter_cell #(
  parameter int CNT_W = 32,
  parameter int INC_W = 4,
  parameter int ADJ   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             adj_en,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] ADJ_V = CNT_W'(ADJ);

  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] added;
  logic [CNT_W-1:0] nxt;

  always_comb begin
    sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
`ifdef PERF_SATURATE_EN
    added = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
`else
    added = sum[CNT_W-1:0];
`endif
    nxt = added;
    // Drain correction happens after the add so the halt cycle still counts.
    if (adj_en) nxt = (added > ADJ_V) ? added - ADJ_V : '0;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      cnt <= nxt;
      ovf <= ovf | sum[CNT_W];
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Event statistics bank: IDLE/RUN/DONE control, NUM_CH weighted channels plus a cycle counter.
// Build option: PERF_SATURATE_EN (saturate on overflow instead of wrapping).
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int INC_W    = DEF_INC_W,
  parameter int HALT_ADJ = DEF_HALT_ADJ,
  localparam int SEL_W   = sel_w(NUM_CH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    halt,
  input  logic                    clear,
  input  logic [NUM_CH*INC_W-1:0] ev_inc,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [CNT_W-1:0]        rd_data,
  output logic [NUM_CH:0]         ovf,
  output logic                    running,
  output logic                    done
);

  state_e                    state;
  logic                      cnt_en;
  logic                      halt_adj;
  logic [NUM_CH:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]          rd_mux;

  assign running  = (state == RUN);
  assign done     = (state == DONE);
  assign cnt_en   = running && !clear;
  assign halt_adj = cnt_en && halt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (halt) state <= DONE;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter_cell #(
      .CNT_W (CNT_W),
      .INC_W (INC_W),
      .ADJ   ((i == 0) ? HALT_ADJ : 0)
    ) u_cell (
      .clock  (clock),
      .reset  (reset),
      .clear  (clear),
      .en     (cnt_en),
      .adj_en ((i == 0) ? halt_adj : 1'b0),
      .inc    (ev_inc[i*INC_W +: INC_W]),
      .cnt    (cnt[i]),
      .ovf    (ovf[i])
    );
  end

  perf_counter_cell #(
    .CNT_W (CNT_W),
    .INC_W (1),
    .ADJ   (0)
  ) u_cyc (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .en     (cnt_en),
    .adj_en (1'b0),
    .inc    (1'b1),
    .cnt    (cnt[NUM_CH]),
    .ovf    (ovf[NUM_CH])
  );

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= NUM_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_mux = cnt[i];
  end

  always_ff @(posedge clock) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed plus random checks of perf_counter_bank against an arithmetic reference model.
// Honors PERF_SATURATE_EN so the model follows the same overflow rule as the build.
module tb_perf_counter_bank;

  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int IW   = 4;
  localparam int ADJ  = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              halt  = 1'b0;
  logic              clear = 1'b0;
  logic [NCH*IW-1:0] ev_inc = '0;
  logic [2:0]        rd_sel = '0;
  logic [CW-1:0]     rd_data;
  logic [NCH:0]      ovf;
  logic              running;
  logic              done;

  int errors = 0;
  int checks = 0;

  // reference model: counts as plain integers, state as 0=idle 1=run 2=done
  int       m_cnt [NCH+1];
  bit [NCH:0] m_ovf;
  int       m_st;
  int       m_rd;

  perf_counter_bank #(
    .NUM_CH(NCH), .CNT_W(CW), .INC_W(IW), .HALT_ADJ(ADJ)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .halt(halt), .clear(clear),
    .ev_inc(ev_inc), .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf),
    .running(running), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int add_ovf(input int ch, input int a, input int b);
    int s = a + b;
    if (s > MAXV) begin
      m_ovf[ch] = 1'b1;
`ifdef PERF_SATURATE_EN
      s = MAXV;
`else
      s = s - (MAXV + 1);
`endif
    end
    return s;
  endfunction

  task automatic model_step();
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ovf = '0; m_st = 0; m_rd = 0;
      return;
    end
    m_rd = (rd_sel <= NCH) ? m_cnt[rd_sel] : 0;
    if (clear) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ovf = '0; m_st = 0;
    end else if (m_st == 1) begin
      for (int i = 0; i < NCH; i++) m_cnt[i] = add_ovf(i, m_cnt[i], int'(ev_inc[i*IW +: IW]));
      m_cnt[NCH] = add_ovf(NCH, m_cnt[NCH], 1);
      if (halt) begin
        m_cnt[0] = (m_cnt[0] > ADJ) ? m_cnt[0] - ADJ : 0;
        m_st = 2;
      end
    end else if (m_st == 0 && start) begin
      m_st = 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("running", 32'(running), 32'(m_st == 1));
    chk("done", 32'(done), 32'(m_st == 2));
  endtask

  task automatic rd(input int sel, input string tag, input int exp);
    rd_sel = 3'(sel);
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ovf = '0; m_st = 0; m_rd = 0;

    // reset state
    tick(); tick();
    chk("rst_rd", 32'(rd_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    // halt in IDLE ignored
    halt = 1'b1; tick(); halt = 1'b0;
    chk("idle_halt_done", 32'(done), 0);

    // halt adjustment: ch0 +2 for 10 cycles, halt on the 10th
    pulse_start();
    chk("start_running", 32'(running), 1);
    ev_inc = 16'h0002;
    for (int i = 0; i < 10; i++) begin
      halt = (i == 9);
      tick();
    end
    halt = 1'b0; ev_inc = '0;
    chk("halt_done", 32'(done), 1);
    chk("halt_running", 32'(running), 0);
    rd(0, "halt_ch0", 12);
    rd(NCH, "halt_cyc", 10);

    // simultaneous events on all channels
    pulse_clear();
    pulse_start();
    ev_inc = {4'd0, 4'd15, 4'd3, 4'd1};
    repeat (4) tick();
    ev_inc = '0;
    rd(0, "sim_ch0", 4);
    rd(1, "sim_ch1", 12);
    rd(2, "sim_ch2", 60);
    rd(3, "sim_ch3", 0);

    // overflow on ch1: 18 x 15 = 270
    pulse_clear();
    pulse_start();
    ev_inc = {4'd0, 4'd0, 4'd15, 4'd0};
    repeat (18) tick();
    ev_inc = '0;
`ifdef PERF_SATURATE_EN
    rd(1, "ovf_ch1", 255);
`else
    rd(1, "ovf_ch1", 14);
`endif
    chk("ovf_bit1", 32'(ovf[1]), 1);

    // clear mid-RUN, then recount from zero
    pulse_clear();
    chk("clr_running", 32'(running), 0);
    chk("clr_ovf", 32'(ovf), 0);
    for (int i = 0; i <= NCH; i++) rd(i, "clr_cnt", 0);
    pulse_start();
    ev_inc = {4'd0, 4'd1, 4'd0, 4'd0};
    repeat (3) tick();
    ev_inc = '0;
    rd(2, "recount_ch2", 3);
    rd(NCH, "run_cyc_pre", 4);

    // halt clamp then freeze in DONE
    pulse_clear();
    pulse_start();
    ev_inc = 16'h0005; tick();
    ev_inc = '0; halt = 1'b1; tick(); halt = 1'b0;
    rd(0, "clamp_ch0", 0);
    ev_inc = '1; start = 1'b1;
    repeat (5) tick();
    ev_inc = '0; start = 1'b0;
    chk("freeze_done", 32'(done), 1);
    rd(0, "freeze_ch0", 0);
    rd(NCH, "freeze_cyc", 2);
    rd(7, "sel_oob", 0);

    // reset mid-RUN behaves as clear and zeroes rd_data
    pulse_clear();
    pulse_start();
    ev_inc = 16'h3333; rd_sel = 3'd1;
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0; ev_inc = '0;
    chk("midrst_rd", 32'(rd_data), 0);
    chk("midrst_running", 32'(running), 0);

    // random traffic checked every cycle by the model
    for (int n = 0; n < 600; n++) begin
      reset  = ($urandom_range(0, 199) == 0);
      clear  = ($urandom_range(0, 59) == 0);
      halt   = ($urandom_range(0, 39) == 0);
      start  = ($urandom_range(0, 7) == 0);
      ev_inc = 16'($urandom);
      rd_sel = 3'($urandom_range(0, 7));
      tick();
    end
    reset = 1'b0; clear = 1'b0; halt = 1'b0; start = 1'b0; ev_inc = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised event-statistics block for the pipelined processor. It accumulates weighted per-cycle event counts on NUM_CH channels (retired instructions, inserted no-ops, mispredicts, and so on) plus a free-running cycle counter. A run/halt/done state machine controls it. The bench wrapper instantiates it beside the processor core, and software or a testbench reads results through a registered select port.

## Interface
Parameters:
- NUM_CH, 4, number of event channels
- CNT_W, 32, width of every counter
- INC_W, 4, width of each per-cycle channel increment
- HALT_ADJ, 8, value subtracted from channel 0 on halt (pipeline drain correction)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin measurement
- halt  in  1  program end detected
- clear  in  1  zero everything and return to IDLE
- ev_inc  in  NUM_CH*INC_W  channel i increment at [i*INC_W +: INC_W]; 0 means no event
- rd_sel  in  $clog2(NUM_CH+1)  0..NUM_CH-1 selects a channel; NUM_CH selects the cycle counter
- rd_data  out  CNT_W  registered read data
- ovf  out  NUM_CH+1  sticky overflow flags; bit NUM_CH is the cycle counter
- running  out  1  state == RUN
- done  out  1  state == DONE

## Operation
- States are IDLE, RUN and DONE.
- Reset forces state IDLE and zeroes all counters, ovf and rd_data. running and done reset to 0.
- Priority order: reset, then clear, then halt, then start.
- clear in any state:
  - Zeroes counters and ovf; next state is IDLE.
  - Events in the clear cycle are discarded.
- IDLE:
  - Counters hold their values.
  - start moves the state to RUN.
  - halt is ignored.
- RUN, every cycle:
  - Channel i becomes cnt[i] + ev_inc[i].
  - The cycle counter adds 1.
  - All channels update independently in the same cycle. No event is dropped when several events are asserted together.
  - start is ignored.
- halt in RUN:
  - The halt cycle's events and cycle count are still accumulated.
  - Channel 0 additionally has HALT_ADJ subtracted after the add, clamped at 0.
  - Next state is DONE.
- DONE:
  - All counters and ovf are frozen.
  - start, halt and ev_inc are ignored.
  - Only clear or reset leaves DONE.
- Arithmetic:
  - Each add is computed at CNT_W+1 bits.
  - A carry out sets the matching ovf bit, which stays set until clear or reset.
  - Result on overflow is set by the Configuration macro.
- Readout:
  - rd_data is the counter selected by rd_sel, sampled at the pre-update value, registered.
  - rd_sel > NUM_CH returns 0.

## Timing
- start sampled at edge t gives running=1 after edge t. The first counting cycle is t+1.
- halt sampled at edge t gives done=1 and running=0 after edge t. The counters after edge t include the halt cycle.
- Read latency is 1 cycle. rd_data after edge t equals the selected counter's value before edge t.
- clear sampled at edge t gives zeroed counters and IDLE state after edge t.
- Reset mid-RUN behaves identically to clear. It also zeroes rd_data.

## Configuration
- PERF_SATURATE_EN defined: an overflowing counter sticks at all-ones and further increments keep it there. The halt adjustment still applies to a saturated channel 0.
- PERF_SATURATE_EN undefined: a counter wraps to the low CNT_W bits of the sum.
- ovf behaves identically in both builds.

## Structure
- Package perf_pkg holds the state enum (IDLE, RUN, DONE), the default width constants and the rd_sel width helper.
- Sub-module perf_counter_cell is one counter with its add, saturate/wrap, sticky overflow and optional halt-adjust clamp. It is instantiated NUM_CH+1 times; the cycle counter uses increment 1 and no adjust.
- The top level holds the FSM, the readout mux and the rd_data register.

## Test plan
- Halt adjustment: reset, start, ch0 inc=2 for 10 cycles, halt on the 10th -> ch0=12, cycle counter=10, done=1, running=0.
- Simultaneous events: inc ch0=1, ch1=3, ch2=15, ch3=0 for 4 cycles -> 4, 12, 60, 0.
- Overflow with CNT_W=8: ch1 inc=15 for 18 cycles (sum 270) -> with PERF_SATURATE_EN ch1=255; without it ch1=14. ovf[1]=1 in both builds.
- Clear mid-RUN with nonzero counters and ovf -> all zero, state IDLE; a new start then counts from 0.
- Halt clamp and freeze: halt with ch0=5 -> ch0=0. Then 5 cycles of ev_inc=all-ones plus start -> counters unchanged, done stays 1.
- Readout: rd_sel=NUM_CH in RUN -> rd_data next cycle equals the pre-edge cycle count. rd_sel=7 with NUM_CH=4 -> rd_data=0.
